midi_rt_parser: RTL and testbench



---
 rtl/midi_rt_parser_if.sv | 21 ++
 rtl/midi_rt_parser.sv | 132 +++++++++++++
 tb/tb_midi_rt_parser.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/midi_rt_parser_if.sv
// Byte stream in, controller events out, for midi_rt_parser.
// The source side uses master; the parser uses slave.
interface midi_rt_parser_if;
    logic [7:0] midi_byte;
    logic       byte_valid;
    logic [7:0] ictrl;
    logic [7:0] ictrl_data;
    logic       pitch_cmd;
    logic       ctrl_cmd;
    logic       rs_valid;

    modport master (
        output midi_byte, byte_valid,
        input  ictrl, ictrl_data, pitch_cmd, ctrl_cmd, rs_valid
    );

    modport slave (
        input  midi_byte, byte_valid,
        output ictrl, ictrl_data, pitch_cmd, ctrl_cmd, rs_valid
    );
endinterface

// File: rtl/midi_rt_parser.sv
// MIDI channel-message parser emitting pitch-bend and control-change strobes.
// Define MIDI_OMNI_EN to accept all 16 channels and ignore CHANNEL.
module midi_rt_parser #(
    parameter int CHANNEL   = 0,
    parameter int PULSE_LEN = 2
) (
    input  logic CLOCK_25,
    input  logic reset_data,
    midi_rt_parser_if.slave bus
);
    localparam logic [3:0] CH   = 4'(CHANNEL);
    localparam logic [3:0] PLEN = 4'(PULSE_LEN);

    typedef enum logic [1:0] {IDLE, D1, D2, SYSEX} state_t;

    state_t     state_q, state_d;
    logic [3:0] rs_type_q, rs_type_d;
    logic       rs_match_q, rs_match_d;
    logic       rs_valid_q, rs_valid_d;
    logic [6:0] d1_q, d1_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pitch_q, pitch_d;
    logic       ctrl_q, ctrl_d;
    logic [7:0] ictrl_q, ictrl_d;
    logic [7:0] data_q, data_d;

    logic       done;
    logic       match;
    logic [7:0] b;

    assign b = bus.midi_byte;

`ifdef MIDI_OMNI_EN
    assign match = 1'b1;
`else
    assign match = (b[3:0] == CH);
`endif

    always_comb begin
        state_d    = state_q;
        rs_type_d  = rs_type_q;
        rs_match_d = rs_match_q;
        rs_valid_d = rs_valid_q;
        d1_d       = d1_q;
        cnt_d      = cnt_q;
        pitch_d    = pitch_q;
        ctrl_d     = ctrl_q;
        ictrl_d    = ictrl_q;
        data_d     = data_q;
        done       = 1'b0;

        if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                pitch_d = 1'b0;
                ctrl_d  = 1'b0;
            end
        end

        // Real-time bytes (F8-FF) fall through untouched.
        if (bus.byte_valid && !(b[7:3] == 5'b11111)) begin
            if (b[7]) begin
                if (b[7:4] != 4'hF) begin
                    rs_type_d  = b[7:4];
                    rs_match_d = match;
                    rs_valid_d = 1'b1;
                    state_d    = D1;
                end else begin
                    rs_valid_d = 1'b0;
                    state_d    = (b == 8'hF0) ? SYSEX : IDLE;
                end
            end else begin
                unique case (state_q)
                    D1: begin
                        d1_d = b[6:0];
                        if (rs_type_q == 4'hC || rs_type_q == 4'hD) begin
                            state_d = D1;
                        end else begin
                            state_d = D2;
                        end
                    end
                    D2: begin
                        done    = 1'b1;
                        state_d = D1;
                    end
                    default: ;
                endcase
            end
        end

        if (done && rs_match_q &&
            (rs_type_q == 4'hE || rs_type_q == 4'hB)) begin
            ictrl_d = {1'b0, d1_q};
            data_d  = {1'b0, b[6:0]};
            pitch_d = (rs_type_q == 4'hE);
            ctrl_d  = (rs_type_q == 4'hB);
            cnt_d   = PLEN;
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset_data) begin
            state_q    <= IDLE;
            rs_type_q  <= 4'd0;
            rs_match_q <= 1'b0;
            rs_valid_q <= 1'b0;
            d1_q       <= 7'd0;
            cnt_q      <= 4'd0;
            pitch_q    <= 1'b0;
            ctrl_q     <= 1'b0;
            ictrl_q    <= 8'd0;
            data_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            rs_type_q  <= rs_type_d;
            rs_match_q <= rs_match_d;
            rs_valid_q <= rs_valid_d;
            d1_q       <= d1_d;
            cnt_q      <= cnt_d;
            pitch_q    <= pitch_d;
            ctrl_q     <= ctrl_d;
            ictrl_q    <= ictrl_d;
            data_q     <= data_d;
        end
    end

    assign bus.ictrl      = ictrl_q;
    assign bus.ictrl_data = data_q;
    assign bus.pitch_cmd  = pitch_q;
    assign bus.ctrl_cmd   = ctrl_q;
    assign bus.rs_valid   = rs_valid_q;
endmodule

// File: tb/tb_midi_rt_parser.sv
// Scoreboard bench for midi_rt_parser: expected events queued on drive,
// popped when the DUT raises or retargets a strobe.
module tb_midi_rt_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;

    midi_rt_parser_if bus ();

    midi_rt_parser #(.CHANNEL(0), .PULSE_LEN(2)) dut (
        .CLOCK_25   (clk),
        .reset_data (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       isp;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_err = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic push(logic isp, logic [7:0] a, logic [7:0] d);
        ev_t e;
        e.isp = isp;
        e.a   = a;
        e.d   = d;
        exp_q.push_back(e);
    endtask

    task automatic send(logic [7:0] v);
        bus.midi_byte  = v;
        bus.byte_valid = 1'b1;
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    logic        pp = 1'b0;
    logic        pc = 1'b0;
    logic [15:0] pbus = 16'd0;

    always @(negedge clk) begin
        logic p, c;
        logic [15:0] cur;
        ev_t e;
        p   = bus.pitch_cmd;
        c   = bus.ctrl_cmd;
        cur = {bus.ictrl, bus.ictrl_data};
        if ((p && !pp) || (c && !pc) || ((p || c) && cur != pbus)) begin
            check("excl", 32'(p & c), 32'd0);
            if (exp_q.size() == 0) begin
                check("sb_extra", {p, c, cur}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event", {15'd0, p, cur}, {15'd0, e.isp, e.a, e.d});
                check("strobe_type", 32'(c), 32'(!e.isp));
            end
        end
        pp   <= p;
        pc   <= c;
        pbus <= cur;
    end

    initial begin
        bus.midi_byte  = 8'd0;
        bus.byte_valid = 1'b0;
        idle(3);
        rst = 1'b0;
        check("rst_ictrl", 32'(bus.ictrl), 32'd0);
        check("rst_data",  32'(bus.ictrl_data), 32'd0);
        check("rst_pitch", 32'(bus.pitch_cmd), 32'd0);
        check("rst_ctrl",  32'(bus.ctrl_cmd), 32'd0);
        check("rst_rsv",   32'(bus.rs_valid), 32'd0);

        push(1'b1, 8'h00, 8'h40);
        send(8'hE0);
        check("rsv_set", 32'(bus.rs_valid), 32'd1);
        send(8'h00);
        send(8'h40);
        check("pb_t1", 32'(bus.pitch_cmd), 32'd1);
        check("pb_lsb", 32'(bus.ictrl), 32'h00);
        check("pb_msb", 32'(bus.ictrl_data), 32'h40);
        idle(1);
        check("pb_t2", 32'(bus.pitch_cmd), 32'd1);
        idle(1);
        check("pb_t3", 32'(bus.pitch_cmd), 32'd0);
        check("pb_hold", 32'(bus.ictrl_data), 32'h40);
        idle(2);

        push(1'b1, 8'h7F, 8'h7F);
        send(8'hE0); send(8'h7F); send(8'h7F);
        idle(3);
        push(1'b1, 8'h01, 8'h00);
        send(8'h01); send(8'h00);
        idle(3);

        push(1'b1, 8'h10, 8'h20);
        send(8'hE0); send(8'h10); send(8'hF8); send(8'h20);
        idle(3);

        push(1'b0, 8'h07, 8'h64);
        send(8'hB0); send(8'h07); send(8'h64);
        idle(3);
        send(8'hF0); send(8'h12); send(8'h34); send(8'hF7);
        check("rsv_sysex", 32'(bus.rs_valid), 32'd0);
        send(8'h35);
        idle(3);
        check("sysex_hold", 32'({bus.ictrl, bus.ictrl_data}), 32'h0764);

`ifdef MIDI_OMNI_EN
        push(1'b1, 8'h00, 8'h40);
`endif
        send(8'hE3); send(8'h00); send(8'h40);
        idle(3);

        send(8'hC0); send(8'h05); send(8'h06);
        send(8'hA0); send(8'h01); send(8'h02);
        idle(3);

        push(1'b0, 8'h11, 8'h22);
        push(1'b0, 8'h33, 8'h44);
        send(8'hB0); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        check("sup_high", 32'(bus.ctrl_cmd), 32'd1);
        idle(1);
        check("sup_t2", 32'(bus.ctrl_cmd), 32'd1);
        idle(1);
        check("sup_end", 32'(bus.ctrl_cmd), 32'd0);
        idle(2);

        push(1'b1, 8'h05, 8'h06);
        send(8'hE0); send(8'h05); send(8'h06);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_drop", 32'(bus.pitch_cmd), 32'd0);
        check("rst_bus", 32'({bus.ictrl, bus.ictrl_data}), 32'd0);

        send(8'hE0); send(8'h00);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send(8'h40);
        idle(4);
        check("mid_ictrl", 32'(bus.ictrl), 32'd0);
        check("mid_data",  32'(bus.ictrl_data), 32'd0);
        check("mid_pitch", 32'(bus.pitch_cmd), 32'd0);
        check("mid_ctrl",  32'(bus.ctrl_cmd), 32'd0);
        check("mid_rsv",   32'(bus.rs_valid), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
